// File: rtl/hazard_pkg.sv
// Shared types and constants for the
// pipeline hazard control unit.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous
// active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         sat;

  assign sat = &cnt_q;

  // Next count: hold at all-ones once reached.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !sat) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, clear wins over increment.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall / flush / freeze control for the
// five-stage pipeline, with perf counters.
module hazard_control_unit
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        use_rs1_id,
  input  logic        use_rs2_id,
  input  logic [4:0]  rd_ex,
  input  logic        mem_read_ex,
  input  logic        branch_taken_ex,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        mem_wb_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  state_e state_q;
  state_e state_d;
  logic   pend_q;
  logic   pend_d;

  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic br;

  logic sel_rst;
  logic sel_frz;
  logic sel_fls;
  logic sel_stl;

  assign rs1_hit = use_rs1_id
                 & (rs1_id == rd_ex);
  assign rs2_hit = use_rs2_id
                 & (rs2_id == rd_ex);
  assign load_use = mem_read_ex
                  & (rd_ex != REG_ZERO)
                  & (rs1_hit | rs2_hit);
  assign br = branch_taken_ex | pend_q;

  // Mutually exclusive priority selects:
  // reset > freeze > flush > stall.
  assign sel_rst = ~arst_n;
  assign sel_frz = arst_n & mem_busy;
  assign sel_fls = arst_n & ~mem_busy & br;
  assign sel_stl = arst_n & ~mem_busy
                 & ~br & load_use;

  // Control outputs from the active select.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    unique case (1'b1)
      sel_rst: begin
      end
      sel_frz: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
      end
      sel_fls: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      sel_stl: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Next state and pending-branch capture.
  // A branch resolved while frozen in
  // MEM_WAIT is remembered until release.
  always_comb begin
    state_d = mem_busy ? MEM_WAIT : RUN;
    pend_d  = pend_q;
    if (mem_busy) begin
      if (state_q == MEM_WAIT
          && branch_taken_ex) begin
        pend_d = 1'b1;
      end
    end else if (br) begin
      pend_d = 1'b0;
    end
  end

  // State registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  sat_counter #(
    .W (PERF_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_n (arst_n),
    .inc   (~pc_write),
    .cnt   (stall_cnt)
  );

  sat_counter #(
    .W (PERF_CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .clr_n (arst_n),
    .inc   (if_id_flush),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for
// hazard_control_unit.
module tb_hazard_control_unit;

  logic        clk;
  logic        arst_n;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic        use_rs1_id;
  logic        use_rs2_id;
  logic [4:0]  rd_ex;
  logic        mem_read_ex;
  logic        branch_taken_ex;
  logic        mem_busy;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_write;
  logic        ex_mem_write;
  logic        mem_wb_write;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // {pc, ifid, idex, exmem, memwb,
  //  bubble, if_id_flush, id_ex_flush}
  localparam logic [7:0] NRM = 8'b11111_000;
  localparam logic [7:0] FRZ = 8'b00000_000;
  localparam logic [7:0] STL = 8'b00111_100;
  localparam logic [7:0] FLS = 8'b11111_011;

  int total;
  int bad;
  logic [7:0] exp_q[$];
  logic [7:0] exp_c;
  logic [7:0] obs_c;
  logic [15:0] stall_m;
  logic [15:0] flush_m;

  hazard_control_unit dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .use_rs1_id      (use_rs1_id),
    .use_rs2_id      (use_rs2_id),
    .rd_ex           (rd_ex),
    .mem_read_ex     (mem_read_ex),
    .branch_taken_ex (branch_taken_ex),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_write    (mem_wb_write),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(
    input logic       rst_n,
    input logic       busy,
    input logic       brt,
    input logic       mrd,
    input logic [4:0] rd,
    input logic [4:0] r1,
    input logic       u1,
    input logic [4:0] r2,
    input logic       u2
  );
    arst_n          = rst_n;
    mem_busy        = busy;
    branch_taken_ex = brt;
    mem_read_ex     = mrd;
    rd_ex           = rd;
    rs1_id          = r1;
    use_rs1_id      = u1;
    rs2_id          = r2;
    use_rs2_id      = u2;
  endtask

  // One cycle: drive at negedge, push the
  // expected controls, check them mid-cycle,
  // then update the counter model and check
  // the counters just after the edge.
  task automatic step(
    input string      tag,
    input logic       rst_n,
    input logic       busy,
    input logic       brt,
    input logic       mrd,
    input logic [4:0] rd,
    input logic [4:0] r1,
    input logic       u1,
    input logic [4:0] r2,
    input logic       u2,
    input logic [7:0] exp,
    input logic       chk_cnt
  );
    @(negedge clk);
    drive(rst_n, busy, brt, mrd,
          rd, r1, u1, r2, u2);
    exp_q.push_back(exp);
    #1;
    exp_c = exp_q.pop_front();
    obs_c = {pc_write, if_id_write,
             id_ex_write, ex_mem_write,
             mem_wb_write, id_ex_bubble,
             if_id_flush, id_ex_flush};
    total++;
    assert (obs_c === exp_c) else begin
      bad++;
      $error("FAIL %s ctrl got=%b want=%b",
             tag, obs_c, exp_c);
    end
    if (!rst_n) begin
      stall_m = 16'd0;
      flush_m = 16'd0;
    end else begin
      if (!exp[7] && stall_m != 16'hFFFF)
        stall_m = stall_m + 16'd1;
      if (exp[1] && flush_m != 16'hFFFF)
        flush_m = flush_m + 16'd1;
    end
    @(posedge clk);
    #1;
    if (chk_cnt) begin
      total++;
      assert (stall_cnt === stall_m) else begin
        bad++;
        $error("FAIL %s stall got=%h want=%h",
               tag, stall_cnt, stall_m);
      end
      total++;
      assert (flush_cnt === flush_m) else begin
        bad++;
        $error("FAIL %s flush got=%h want=%h",
               tag, flush_cnt, flush_m);
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    stall_m = 16'd0;
    flush_m = 16'd0;
    drive(1'b0, 1'b0, 1'b0, 1'b0,
          5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

    // reset dominates busy/load-use inputs
    step("rst0", 0,1,0,1, 5'd5,5'd5,1, 5'd0,0, NRM, 1);
    step("rst1", 0,0,1,1, 5'd5,5'd5,1, 5'd0,0, NRM, 1);
    step("idle", 1,0,0,0, 5'd0,5'd0,0, 5'd0,0, NRM, 1);

    // load-use on rs1, then hazard gone
    step("lu1",  1,0,0,1, 5'd5,5'd5,1, 5'd0,0, STL, 1);
    step("lu1x", 1,0,0,0, 5'd9,5'd5,1, 5'd0,0, NRM, 1);
    // load-use on rs2
    step("lu2",  1,0,0,1, 5'd12,5'd3,1, 5'd12,1, STL, 1);
    // x0 and unused source never stall
    step("x0",   1,0,0,1, 5'd0,5'd0,1, 5'd0,1, NRM, 1);
    step("nuse", 1,0,0,1, 5'd7,5'd1,0, 5'd7,0, NRM, 1);
    step("nold", 1,0,0,0, 5'd7,5'd7,1, 5'd7,1, NRM, 1);

    // 3-cycle freeze then release
    step("frz1", 1,1,0,0, 5'd0,5'd0,0, 5'd0,0, FRZ, 1);
    step("frz2", 1,1,0,0, 5'd0,5'd0,0, 5'd0,0, FRZ, 1);
    step("frz3", 1,1,0,0, 5'd0,5'd0,0, 5'd0,0, FRZ, 1);
    step("rel",  1,0,0,0, 5'd0,5'd0,0, 5'd0,0, NRM, 1);

    // branch pulses in cycle 2 of a freeze
    step("bf1",  1,1,0,0, 5'd0,5'd0,0, 5'd0,0, FRZ, 1);
    step("bf2",  1,1,1,0, 5'd0,5'd0,0, 5'd0,0, FRZ, 1);
    step("bf3",  1,1,0,0, 5'd0,5'd0,0, 5'd0,0, FRZ, 1);
    step("bfrl", 1,0,0,0, 5'd0,5'd0,0, 5'd0,0, FLS, 1);
    step("bfdn", 1,0,0,0, 5'd0,5'd0,0, 5'd0,0, NRM, 1);

    // branch beats load-use
    step("brlu", 1,0,1,1, 5'd4,5'd4,1, 5'd0,0, FLS, 1);
    step("brrn", 1,0,1,0, 5'd0,5'd0,0, 5'd0,0, FLS, 1);
    // freeze beats branch
    step("frbr", 1,1,1,0, 5'd0,5'd0,0, 5'd0,0, FRZ, 1);
    // release cycle with load-use stalls
    step("rllu", 1,0,0,1, 5'd6,5'd0,0, 5'd6,1, STL, 1);
    step("post", 1,0,0,0, 5'd0,5'd0,0, 5'd0,0, NRM, 1);

    // long freeze saturates stall_cnt
    for (int i = 0; i < 70000; i++) begin
      step("sat", 1,1,0,0, 5'd0,5'd0,0, 5'd0,0,
           FRZ, (i == 69999));
    end
    total++;
    assert (stall_cnt === 16'hFFFF) else begin
      bad++;
      $error("FAIL satv got=%h want=ffff",
             stall_cnt);
    end
    // set a pending branch, then reset
    step("spnd", 1,1,1,0, 5'd0,5'd0,0, 5'd0,0, FRZ, 1);
    step("mrst", 0,1,0,0, 5'd0,5'd0,0, 5'd0,0, NRM, 1);
    // RUN after reset: busy+branch must
    // not latch a pending branch
    step("arun", 1,1,1,0, 5'd0,5'd0,0, 5'd0,0, FRZ, 1);
    step("anop", 1,0,0,0, 5'd0,5'd0,0, 5'd0,0, NRM, 1);

    // reset mid-stall
    step("mstl", 0,0,0,1, 5'd5,5'd5,1, 5'd0,0, NRM, 1);
    step("end",  1,0,0,0, 5'd0,5'd0,0, 5'd0,0, NRM, 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
